fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Parametrised instruction-fetch stage for the MIPS pipeline.
- Holds the PC and presents the fetch address to an external combinational instruction memory.
- Registers the fetched word, its PC and PC+4 into an IF/ID output register with a valid bit.
- Adds stall, branch/jump redirect with flush, and a halt-detect state machine that freezes fetch until redirected.

Parameters:
- ADDR_W, 32, width of PC and memory address (minimum 3).
- DATA_W, 32, instruction width.
- RESET_PC, 0, PC value after reset; bits [1:0] must be 0.
- HALT_INSTR, 32'hFFFF_FFFF, encoding that triggers halt (truncated or zero-extended to DATA_W).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_stall  in  1  hazard unit: hold PC and IF/ID contents.
- i_redirect  in  1  branch/jump taken: load new PC and flush IF/ID.
- i_redirect_pc  in  ADDR_W  redirect target; bits [1:0] are ignored and treated as 0.
- o_imem_addr  out  ADDR_W  equals current PC, combinational.
- i_imem_rdata  in  DATA_W  instruction at o_imem_addr, same cycle.
- o_instr  out  DATA_W  IF/ID instruction.
- o_pc  out  ADDR_W  IF/ID PC of o_instr.
- o_next_pc  out  ADDR_W  IF/ID PC+4 of o_instr.
- o_valid  out  1  IF/ID holds a real instruction.
- o_halted  out  1  FSM is in HALT.

Behaviour:
- Reset values:
  - PC = RESET_PC; FSM = RUN.
  - o_instr = 0 (NOP); o_pc = 0; o_next_pc = 0; o_valid = 0; o_halted = 0.
  - Reset overrides every other input.
- PC arithmetic:
  - pc_plus4 = PC + 4, modulo 2^ADDR_W; the all-ones-aligned address wraps to 0.
  - A redirect loads {i_redirect_pc[ADDR_W-1:2], 2'b00}.
- Latency: a word fetched at PC in cycle n appears on o_instr, o_pc and o_next_pc in cycle n+1 with o_valid=1.
- Per-edge priority (highest first):
  1. reset: apply reset values.
  2. i_redirect:
     - PC <= target.
     - IF/ID <= bubble (instr 0, valid 0; o_pc and o_next_pc hold).
     - FSM <= RUN.
     - Applies even when i_stall=1 or the FSM is in HALT.
  3. i_stall: PC, IF/ID and FSM all hold.
  4. FSM = HALT:
     - PC holds.
     - IF/ID <= bubble.
  5. FSM = RUN, i_imem_rdata == HALT_INSTR:
     - IF/ID captures the halt word with valid=1.
     - PC holds at the halt address.
     - FSM <= HALT.
  6. FSM = RUN, normal fetch:
     - IF/ID captures {rdata, PC, pc_plus4} with valid=1.
     - PC <= pc_plus4.
- FSM states:
  - RUN -> HALT on rule 5.
  - HALT -> RUN only on i_redirect or reset.
  - o_halted = (state == HALT), registered.
- Boundary cases:
  - A stall in the same cycle a halt word is fetched defers the halt. The halt is detected when the stall drops and the word is still present.
  - Redirect and halt word in the same cycle: redirect wins and the halt is not taken.
  - Redirect to the current PC is legal and still flushes IF/ID.
  - Reset asserted mid-stall or in HALT returns to RUN at RESET_PC on the next edge.
- There are no combinational paths from inputs to outputs other than o_imem_addr = PC.

Test Plan:
- Sequential fetch from reset, memory word = address, no stall/redirect:
  - Cycles 1..4 show o_pc = 0, 4, 8, 12.
  - o_next_pc = 4, 8, 12, 16; o_instr = o_pc; o_valid = 1.
- Stall held 3 cycles while PC=8:
  - o_imem_addr stays 8.
  - IF/ID stays {instr 4, pc 4, next 8} for 3 cycles.
  - After the stall drops, o_pc = 8 and the sequence resumes.
- i_redirect with i_redirect_pc = 0x103 while i_stall = 1:
  - Next cycle o_imem_addr = 0x100, o_valid = 0, o_instr = 0.
  - The following cycle o_pc = 0x100.
- HALT_INSTR placed at 0x10:
  - o_pc = 0x10 with valid = 1, then o_halted = 1.
  - o_imem_addr stays 0x10 and o_valid = 0 for 5 or more cycles.
  - Redirect to 0x40 clears o_halted and fetch resumes at 0x40.
- ADDR_W = 8, redirect to 0xFC:
  - o_pc = 0xFC, o_next_pc = 0x00, then o_pc = 0x00.
- Reset pulsed while halted and stalled:
  - One edge later, o_imem_addr = RESET_PC, o_halted = 0, o_valid = 0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction-fetch stage.
// Holds the PC, presents it to a combinational instruction memory and registers
// the fetched word, its PC and PC+4 into the IF/ID register. It supports stall,
// branch/jump redirect with flush, and a halt detector that freezes fetch until
// the next redirect or reset.
module fetch_unit #(
   parameter int                 ADDR_W     = 32,
   parameter int                 DATA_W     = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
   // Typing the parameter as DATA_W bits truncates or zero-extends any override.
   parameter logic [DATA_W-1:0]  HALT_INSTR = DATA_W'(32'hFFFF_FFFF)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_stall,
   input  logic              i_redirect,
   input  logic [ADDR_W-1:0] i_redirect_pc,
   output logic [ADDR_W-1:0] o_imem_addr,
   input  logic [DATA_W-1:0] i_imem_rdata,
   output logic [DATA_W-1:0] o_instr,
   output logic [ADDR_W-1:0] o_pc,
   output logic [ADDR_W-1:0] o_next_pc,
   output logic              o_valid,
   output logic              o_halted
);

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_plus4;
   logic [ADDR_W-1:0] redirect_target;

   // Sequential PC; the all-ones aligned address wraps naturally to zero.
   assign pc_plus4        = pc + ADDR_W'(4);
   // Targets are word aligned: the two low bits of the request are dropped.
   assign redirect_target = {i_redirect_pc[ADDR_W-1:2], 2'b00};

   // The memory address is the only combinational output.
   assign o_imem_addr = pc;
   assign o_halted    = (state == HALT);

   // PC, IF/ID register and halt FSM, updated in strict priority order.
   // NOTE: non-blocking assignments so every register samples pre-edge values;
   // branches that assign nothing simply hold, which is a flop, not a latch.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc        <= RESET_PC;
         state     <= RUN;
         o_instr   <= '0;
         o_pc      <= '0;
         o_next_pc <= '0;
         o_valid   <= 1'b0;
      end else if (i_redirect) begin
         // Flush: bubble in IF/ID, its PC fields keep their last values.
         pc      <= redirect_target;
         state   <= RUN;
         o_instr <= '0;
         o_valid <= 1'b0;
      end else if (i_stall) begin
         // Hazard hold: PC, IF/ID and FSM all keep their values.
      end else if (state == HALT) begin
         // Frozen: PC stays on the halt word, IF/ID keeps emitting bubbles.
         o_instr <= '0;
         o_valid <= 1'b0;
      end else begin
         o_instr   <= i_imem_rdata;
         o_pc      <= pc;
         o_next_pc <= pc_plus4;
         o_valid   <= 1'b1;
         if (i_imem_rdata == HALT_INSTR) begin
            // Halt word passes down the pipe once; PC parks on its address.
            state <= HALT;
         end else begin
            pc <= pc_plus4;
         end
      end
   end

endmodule
